// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter: line-format
// enums, FSM states, stop-length and data-width helpers, masked parity.
package uart_pkg;

    localparam int unsigned DbitLimit = 9;

    typedef enum logic [1:0] {ParNone, ParEven, ParOdd} parity_t;
    typedef enum logic [1:0] {StopOne, StopOneHalf, StopTwo} stop_t;
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_t;

    // Code 11 is reserved and falls back to no parity.
    function automatic parity_t decode_parity(logic [1:0] code);
        case (code)
            2'b01:   return ParEven;
            2'b10:   return ParOdd;
            default: return ParNone;
        endcase
    endfunction

    // Code 11 is reserved and falls back to two stop bits.
    function automatic stop_t decode_stop(logic [1:0] code);
        case (code)
            2'b00:   return StopOne;
            2'b01:   return StopOneHalf;
            default: return StopTwo;
        endcase
    endfunction

    function automatic int unsigned stop_ticks(stop_t stop, int unsigned os);
        case (stop)
            StopOneHalf: return (os * 3) / 2;
            StopTwo:     return 2 * os;
            default:     return os;
        endcase
    endfunction

    function automatic logic [3:0] clamp_dbit(logic [3:0] dbit, int unsigned dbit_max);
        if (dbit < 4'd5) return 4'd5;
        if ({28'd0, dbit} > dbit_max) return 4'(dbit_max);
        return dbit;
    endfunction

    // XOR of the low dbit bits of word; bits above the frame width are ignored.
    function automatic logic masked_parity(logic [DbitLimit-1:0] word, logic [3:0] dbit);
        logic p;
        p = 1'b0;
        for (int i = 0; i < int'(DbitLimit); i++) begin
            if (i < int'(dbit)) p = p ^ word[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake and per-frame line format for the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DBIT_MAX = 9
) ();

    logic                tx_valid;
    logic                tx_ready;
    logic [DBIT_MAX-1:0] din;
    logic [3:0]          cfg_dbit;
    logic [1:0]          cfg_parity;
    logic [1:0]          cfg_stop;

    modport master (
        output tx_valid, din, cfg_dbit, cfg_parity, cfg_stop,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, din, cfg_dbit, cfg_parity, cfg_stop,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..DBIT_MAX data bits LSB first,
// optional parity, 1/1.5/2 stop bits, paced by the oversampling tick s_tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DBIT_MAX = 9,
    parameter int unsigned OS       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tick,
    uart_tx_cfg_if.slave bus,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done_tick
);

    localparam int unsigned CntW = $clog2(2 * OS);

    tx_state_t           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          dbit_q, dbit_d;
    logic [DBIT_MAX-1:0] shreg_q, shreg_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    stop_t               stop_q, stop_d;
    logic                tx_q, line;

    logic [DbitLimit-1:0] din_ext;
    logic [3:0]           dbit_cl;
    parity_t              par_cfg;
    logic                 tick_last;
    logic                 stop_last;

    always_comb begin
        din_ext                 = '0;
        din_ext[DBIT_MAX-1:0]   = bus.din;
    end

    assign dbit_cl   = clamp_dbit(bus.cfg_dbit, DBIT_MAX);
    assign par_cfg   = decode_parity(bus.cfg_parity);
    assign tick_last = (cnt_q == CntW'(OS - 1));
    assign stop_last = (cnt_q == CntW'(stop_ticks(stop_q, OS) - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        dbit_d       = dbit_q;
        shreg_d      = shreg_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop_d       = stop_q;
        tx_done_tick = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An s_tick coinciding with accept is deliberately not counted.
                if (bus.tx_valid) begin
                    shreg_d   = bus.din;
                    dbit_d    = dbit_cl;
                    par_en_d  = (par_cfg != ParNone);
                    par_bit_d = masked_parity(din_ext, dbit_cl) ^ (par_cfg == ParOdd);
                    stop_d    = decode_stop(bus.cfg_stop);
                    cnt_d     = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (tick_last) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = StData;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (tick_last) begin
                        cnt_d   = '0;
                        shreg_d = shreg_q >> 1;
                        if (idx_q == dbit_q - 4'd1) begin
                            state_d = par_en_q ? StParity : StStop;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StParity: begin
                if (s_tick) begin
                    if (tick_last) begin
                        cnt_d   = '0;
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (stop_last) begin
                        cnt_d        = '0;
                        tx_done_tick = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        line = 1'b1;
        unique case (state_q)
            StStart:  line = 1'b0;
            StData:   line = shreg_q[0];
            StParity: line = par_bit_q;
            default:  line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            dbit_q    <= 4'd8;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= StopOne;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dbit_q    <= dbit_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop_q    <= stop_d;
            tx_q      <= line;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != StIdle);
    assign bus.tx_ready = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected line fields are queued per frame and
// compared at each field midpoint, along with handshake and done-tick timing.
module tb_uart_tx_cfg;

    localparam int unsigned DbitMax = 9;
    localparam int          Os      = 16;

    typedef struct {
        logic val;
        int   ticks;
    } field_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_tick = 1'b0;
    logic tick_gate = 1'b1;
    logic tx, tx_busy, tx_done_tick;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    field_t      exp_q[$];

    uart_tx_cfg_if #(.DBIT_MAX(DbitMax)) bus ();

    uart_tx_cfg #(
        .DBIT_MAX(DbitMax),
        .OS      (Os)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tick      (s_tick),
        .bus         (bus),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    // s_tick changes 2 time units after posedge so it is stable at the sampling negedge.
    initial begin : tick_gen
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #2;
            s_tick = tick_gate && (phase == 3);
            phase  = (phase + 1) % 4;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [8:0] d, input logic [3:0] db, input logic [1:0] par,
                              input logic [1:0] st, output int total, output int n);
        field_t f;
        logic   p;
        n = (db < 4'd5) ? 5 : ((db > 4'd9) ? 9 : int'(db));
        f.val = 1'b0; f.ticks = Os; exp_q.push_back(f);
        total = Os;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.val = d[i]; f.ticks = Os; exp_q.push_back(f);
            p = p ^ d[i];
            total += Os;
        end
        if (par == 2'b01 || par == 2'b10) begin
            f.val = (par == 2'b10) ? ~p : p; f.ticks = Os; exp_q.push_back(f);
            total += Os;
        end
        f.val   = 1'b1;
        f.ticks = (st == 2'b00) ? Os : ((st == 2'b01) ? (Os * 3) / 2 : 2 * Os);
        exp_q.push_back(f);
        total += f.ticks;
    endtask

    // mode: 0 plain, 1 perturb inputs during frame, 2 stall ticks in parity, 3 reset in data bit 3
    task automatic run_frame(input string tag, input logic [8:0] d, input logic [3:0] db,
                             input logic [1:0] par, input logic [1:0] st, input int mode);
        int     total, n, t, fstart, fidx, clocks, done_at;
        bit     sampled, done, stall_ok, bad_accept;
        field_t cur;
        push_frame(d, db, par, st, total, n);
        @(negedge clk);
        check_eq({tag, " ready_idle"}, 32'(bus.tx_ready), 32'd1);
        bus.din = d; bus.cfg_dbit = db; bus.cfg_parity = par; bus.cfg_stop = st;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check_eq({tag, " ready_low"}, 32'(bus.tx_ready), 32'd0);
        check_eq({tag, " busy"}, 32'(tx_busy), 32'd1);
        check_eq({tag, " tx_lag"}, 32'(tx), 32'd1);
        t = 0; fstart = 0; fidx = 0; clocks = 0; done_at = -1;
        sampled = 1'b0; done = 1'b0; bad_accept = 1'b0;
        cur = exp_q.pop_front();
        while (!done && clocks < 20000) begin
            if (clocks == 1) check_eq({tag, " tx_fall"}, 32'(tx), 32'd0);
            if (!sampled && t == fstart + cur.ticks / 2) begin
                sampled = 1'b1;
                check_eq($sformatf("%s bit%0d", tag, fidx), 32'(tx), 32'(cur.val));
                if (mode == 3 && fidx == 4) begin
                    rst = 1'b1;
                    #1;
                    check_eq({tag, " rst_tx"}, 32'(tx), 32'd1);
                    check_eq({tag, " rst_ready"}, 32'(bus.tx_ready), 32'd1);
                    check_eq({tag, " rst_busy"}, 32'(tx_busy), 32'd0);
                    check_eq({tag, " rst_done"}, 32'(tx_done_tick), 32'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    return;
                end
                if (mode == 2 && fidx == n + 1) begin
                    tick_gate = 1'b0;
                    stall_ok  = 1'b1;
                    repeat (50) begin
                        @(negedge clk);
                        if (tx !== cur.val || tx_busy !== 1'b1) stall_ok = 1'b0;
                    end
                    check_eq({tag, " stall_hold"}, 32'(stall_ok), 32'd1);
                    tick_gate = 1'b1;
                end
            end
            if (tx_done_tick) begin
                done    = 1'b1;
                done_at = t + 1;
                bus.tx_valid = 1'b0;
            end else if (mode == 1) begin
                bus.tx_valid   = 1'($urandom_range(0, 1));
                bus.din        = 9'($urandom);
                bus.cfg_dbit   = 4'($urandom);
                bus.cfg_parity = 2'($urandom);
                bus.cfg_stop   = 2'($urandom);
            end
            if (bus.tx_valid && bus.tx_ready) bad_accept = 1'b1;
            if (s_tick) begin
                t++;
                if (t == fstart + cur.ticks && exp_q.size() > 0) begin
                    fstart  = t;
                    fidx++;
                    cur     = exp_q.pop_front();
                    sampled = 1'b0;
                end
            end
            @(negedge clk);
            clocks++;
        end
        check_eq({tag, " done_seen"}, 32'(done), 32'd1);
        check_eq({tag, " done_tick"}, 32'(done_at), 32'(total));
        check_eq({tag, " fields_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, " ready_back"}, 32'(bus.tx_ready), 32'd1);
        check_eq({tag, " busy_clear"}, 32'(tx_busy), 32'd0);
        check_eq({tag, " done_pulse"}, 32'(tx_done_tick), 32'd0);
        if (mode == 1) check_eq({tag, " no_accept"}, 32'(bad_accept), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus.tx_valid = 1'b0; bus.din = '0; bus.cfg_dbit = 4'd8;
        bus.cfg_parity = 2'b00; bus.cfg_stop = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("reset tx", 32'(tx), 32'd1);
        check_eq("reset ready", 32'(bus.tx_ready), 32'd1);
        check_eq("reset busy", 32'(tx_busy), 32'd0);
        check_eq("reset done", 32'(tx_done_tick), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("8N1",      9'h055, 4'd8,  2'b00, 2'b00, 0);
        run_frame("7E1",      9'h041, 4'd7,  2'b01, 2'b00, 0);
        run_frame("8O2",      9'h0FF, 4'd8,  2'b10, 2'b10, 0);
        run_frame("9N1.5",    9'h1AA, 4'd9,  2'b00, 2'b01, 1);
        run_frame("rst_mid",  9'h0C3, 4'd8,  2'b00, 2'b00, 3);
        run_frame("post_rst", 9'h0C3, 4'd8,  2'b00, 2'b00, 0);
        run_frame("stall",    9'h05A, 4'd8,  2'b01, 2'b00, 2);
        run_frame("dbit2",    9'h013, 4'd2,  2'b00, 2'b00, 0);
        run_frame("dbit12",   9'h155, 4'd12, 2'b11, 2'b11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
